// File: rtl/cpu_pkg.sv
// Shared MIPS core constants: control bundle layout and the hard-wired zero register.
package cpu_pkg;
  localparam int CTRL_W          = 10;
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary: decoded ID fields and write-back port in, latched EX fields out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = cpu_pkg::CTRL_W
);
  logic              id_valid_i;
  logic [ADDR_W-1:0] id_rs_addr_i;
  logic [ADDR_W-1:0] id_rt_addr_i;
  logic [ADDR_W-1:0] id_rd_addr_i;
  logic [DATA_W-1:0] id_rs_data_i;
  logic [DATA_W-1:0] id_rt_data_i;
  logic              id_uses_rs_i;
  logic              id_uses_rt_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              wb_reg_write_i;
  logic [ADDR_W-1:0] wb_rd_addr_i;
  logic [DATA_W-1:0] wb_rd_data_i;
  logic              stall_i;
  logic              flush_i;

  logic              ex_valid_o;
  logic [ADDR_W-1:0] ex_rs_addr_o;
  logic [ADDR_W-1:0] ex_rt_addr_o;
  logic [ADDR_W-1:0] ex_rd_addr_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              hazard_stall_o;

  modport master (
    output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
           id_rs_data_i, id_rt_data_i, id_uses_rs_i, id_uses_rt_i,
           id_imm_i, id_ctrl_i, wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i,
           stall_i, flush_i,
    input  ex_valid_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
           ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_ctrl_o, hazard_stall_o
  );

  modport slave (
    input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
           id_rs_data_i, id_rt_data_i, id_uses_rs_i, id_uses_rt_i,
           id_imm_i, id_ctrl_i, wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i,
           stall_i, flush_i,
    output ex_valid_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
           ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_ctrl_o, hazard_stall_o
  );
endinterface

// File: rtl/id_ex_stage_bypass.sv
// Operand selection for one register read: $0 reads zero, a same-cycle write-back wins
// over the (not yet updated) register-file data.
module operand_bypass
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              wb_reg_write_i,
  input  logic [ADDR_W-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_rd_data_i,
  output logic [DATA_W-1:0] operand_o
);
  always_comb begin
    operand_o = rf_data_i;
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      operand_o = '0;
    end else if (wb_reg_write_i && (wb_rd_addr_i == addr_i)) begin
      operand_o = wb_rd_data_i;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, $0 zeroing, load-use hazard detection,
// stall (hold) and flush/hazard (bubble insertion).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  id_ex_stage_if.slave bus
);
  logic [1:0][ADDR_W-1:0] op_addr;
  logic [1:0][DATA_W-1:0] op_rf;
  logic [1:0][DATA_W-1:0] op_val;

  assign op_addr[0] = bus.id_rs_addr_i;
  assign op_addr[1] = bus.id_rt_addr_i;
  assign op_rf[0]   = bus.id_rs_data_i;
  assign op_rf[1]   = bus.id_rt_data_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    operand_bypass #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bypass (
      .addr_i        (op_addr[gi]),
      .rf_data_i     (op_rf[gi]),
      .wb_reg_write_i(bus.wb_reg_write_i),
      .wb_rd_addr_i  (bus.wb_rd_addr_i),
      .wb_rd_data_i  (bus.wb_rd_data_i),
      .operand_o     (op_val[gi])
    );
  end

  logic              valid_q,   valid_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic              hazard;

  // A load in EX cannot forward in time to an ID consumer of its destination.
  assign hazard = valid_q && ctrl_q[cpu_pkg::CTRL_MEM_READ]
               && (rd_addr_q != ADDR_W'(cpu_pkg::REG_ZERO)) && bus.id_valid_i
               && ((bus.id_uses_rs_i && (bus.id_rs_addr_i == rd_addr_q))
                || (bus.id_uses_rt_i && (bus.id_rt_addr_i == rd_addr_q)));

  assign bus.hazard_stall_o = hazard && !bus.stall_i;

  always_comb begin
    valid_d   = valid_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    if (!bus.stall_i) begin
      if (bus.flush_i || hazard) begin
        valid_d   = 1'b0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        ctrl_d    = '0;
      end else begin
        valid_d   = bus.id_valid_i;
        rs_addr_d = bus.id_rs_addr_i;
        rt_addr_d = bus.id_rt_addr_i;
        rd_addr_d = bus.id_rd_addr_i;
        rs_data_d = op_val[0];
        rt_data_d = op_val[1];
        imm_d     = bus.id_imm_i;
        ctrl_d    = bus.id_valid_i ? bus.id_ctrl_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_rs_addr_o = rs_addr_q;
  assign bus.ex_rt_addr_o = rt_addr_q;
  assign bus.ex_rd_addr_o = rd_addr_q;
  assign bus.ex_rs_data_o = rs_data_q;
  assign bus.ex_rt_data_o = rt_data_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_ctrl_o    = ctrl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: operand table, directed hazard/stall/flush/reset sequences, and
// randomized traffic against a rule-level model of the EX register contents.
module tb_id_ex_stage;
  localparam int MEM_READ_BIT = 8;
  localparam logic [9:0] CTRL_LW  = 10'h360;  // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [9:0] CTRL_ADD = 10'h202;  // reg_write, alu_op=2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [9:0]  ctrl;
  } ex_t;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] exp_rs, exp_rt;
  } vec_t;

  ex_t  m;
  vec_t vt[8];
  int   tests = 0;
  int   fails = 0;
  int   txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Value an instruction should see for one source register this cycle.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_reg_write_i && bus.wb_rd_addr_i == a) return bus.wb_rd_data_i;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    logic reads_it;
    reads_it = (bus.id_uses_rs_i && bus.id_rs_addr_i == m.rd) ||
               (bus.id_uses_rt_i && bus.id_rt_addr_i == m.rd);
    return m.v && m.ctrl[MEM_READ_BIT] && m.rd != 5'd0 && bus.id_valid_i && reads_it;
  endfunction

  task automatic check_ex(input string tag);
    check({tag, " valid"},   32'(bus.ex_valid_o),   32'(m.v));
    check({tag, " rs_addr"}, 32'(bus.ex_rs_addr_o), 32'(m.rs));
    check({tag, " rt_addr"}, 32'(bus.ex_rt_addr_o), 32'(m.rt));
    check({tag, " rd_addr"}, 32'(bus.ex_rd_addr_o), 32'(m.rd));
    check({tag, " rs_data"}, bus.ex_rs_data_o,      m.rsd);
    check({tag, " rt_data"}, bus.ex_rt_data_o,      m.rtd);
    check({tag, " imm"},     bus.ex_imm_o,          m.imm);
    check({tag, " ctrl"},    32'(bus.ex_ctrl_o),    32'(m.ctrl));
  endtask

  // One clock: check the combinational stall request, advance the model, check EX.
  task automatic step(input string tag);
    logic hz;
    #1;
    hz = ref_hazard();
    check({tag, " hazard_stall"}, 32'(bus.hazard_stall_o), 32'(hz && !bus.stall_i));
    @(posedge clk);
    #1;
    if (!bus.stall_i) begin
      if (bus.flush_i || hz) begin
        m = '0;
      end else begin
        m.v    = bus.id_valid_i;
        m.rs   = bus.id_rs_addr_i;
        m.rt   = bus.id_rt_addr_i;
        m.rd   = bus.id_rd_addr_i;
        m.rsd  = ref_operand(bus.id_rs_addr_i, bus.id_rs_data_i);
        m.rtd  = ref_operand(bus.id_rt_addr_i, bus.id_rt_data_i);
        m.imm  = bus.id_imm_i;
        m.ctrl = bus.id_valid_i ? bus.id_ctrl_i : 10'd0;
      end
    end
    check_ex(tag);
    txn++;
    $display("[TB] txn %0d %s: stall=%0b flush=%0b hz=%0b -> valid=%0b rd=%0d ctrl=%03h rs=%08h rt=%08h",
             txn, tag, bus.stall_i, bus.flush_i, hz, bus.ex_valid_o, bus.ex_rd_addr_o,
             bus.ex_ctrl_o, bus.ex_rs_data_o, bus.ex_rt_data_o);
  endtask

  task automatic idle();
    bus.id_valid_i = 0; bus.id_rs_addr_i = 0; bus.id_rt_addr_i = 0; bus.id_rd_addr_i = 0;
    bus.id_rs_data_i = 0; bus.id_rt_data_i = 0; bus.id_uses_rs_i = 0; bus.id_uses_rt_i = 0;
    bus.id_imm_i = 0; bus.id_ctrl_i = 0; bus.wb_reg_write_i = 0; bus.wb_rd_addr_i = 0;
    bus.wb_rd_data_i = 0; bus.stall_i = 0; bus.flush_i = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic [9:0] ctrl);
    bus.id_valid_i = 1; bus.id_rs_addr_i = rs; bus.id_rt_addr_i = rt; bus.id_rd_addr_i = rd;
    bus.id_uses_rs_i = urs; bus.id_uses_rt_i = urt; bus.id_ctrl_i = ctrl;
    bus.id_rs_data_i = 32'h100 + 32'(rs); bus.id_rt_data_i = 32'h200 + 32'(rt);
    bus.id_imm_i = 32'hABC0 + 32'(rd);
  endtask

  initial begin
    idle();
    m = '0;
    vt[0] = '{5'd5,  5'd6, 32'h11,   32'h22,   1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h22};
    vt[1] = '{5'd3,  5'd0, 32'h1,    32'h55,   1'b1, 5'd0,  32'h77,       32'h1,        32'h0};
    vt[2] = '{5'd0,  5'd0, 32'hAAAA, 32'hBBBB, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0};
    vt[3] = '{5'd7,  5'd7, 32'hC1,   32'hC2,   1'b1, 5'd7,  32'h99,       32'h99,       32'h99};
    vt[4] = '{5'd7,  5'd8, 32'hC1,   32'hC2,   1'b0, 5'd7,  32'h99,       32'hC1,       32'hC2};
    vt[5] = '{5'd31, 5'd30, 32'h1234, 32'h5678, 1'b1, 5'd30, 32'hFFFFFFFF, 32'h1234,   32'hFFFFFFFF};
    vt[6] = '{5'd1,  5'd2, 32'h10,   32'h20,   1'b1, 5'd3,  32'h30,       32'h10,       32'h20};
    vt[7] = '{5'd0,  5'd4, 32'h5,    32'h6,    1'b1, 5'd0,  32'h7,        32'h0,        32'h6};

    #12;
    check_ex("reset");
    check("reset hazard_stall", 32'(bus.hazard_stall_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("idle");

    // Operand bypass table.
    foreach (vt[i]) begin
      set_id(vt[i].rs, vt[i].rt, 5'd9, 1, 1, CTRL_ADD);
      bus.id_rs_data_i = vt[i].rsd; bus.id_rt_data_i = vt[i].rtd;
      bus.wb_reg_write_i = vt[i].we; bus.wb_rd_addr_i = vt[i].wa; bus.wb_rd_data_i = vt[i].wd;
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d table rs", i), bus.ex_rs_data_o, vt[i].exp_rs);
      check($sformatf("vec%0d table rt", i), bus.ex_rt_data_o, vt[i].exp_rt);
    end
    idle();

    // Load-use: lw r8 then add reading r8 via rt.
    set_id(5'd2, 5'd0, 5'd8, 1, 0, CTRL_LW);
    step("lw r8");
    set_id(5'd3, 5'd8, 5'd9, 1, 1, CTRL_ADD);
    #1 check("loaduse hazard", 32'(bus.hazard_stall_o), 32'd1);
    step("add bubble");
    check("loaduse bubble valid", 32'(bus.ex_valid_o), 32'd0);
    check("loaduse bubble ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    step("add capture");
    check("loaduse add valid", 32'(bus.ex_valid_o), 32'd1);
    check("loaduse add rt", 32'(bus.ex_rt_addr_o), 32'd8);

    // No stall: rt not used, $0 load, invalid consumer.
    set_id(5'd2, 5'd0, 5'd8, 1, 0, CTRL_LW);
    step("lw r8 b");
    set_id(5'd9, 5'd8, 5'd10, 1, 0, CTRL_ADD);
    #1 check("addi no-rt hazard", 32'(bus.hazard_stall_o), 32'd0);
    step("addi");
    set_id(5'd2, 5'd0, 5'd0, 1, 0, CTRL_LW);
    step("lw r0");
    set_id(5'd0, 5'd0, 5'd11, 1, 1, CTRL_ADD);
    #1 check("r0 load hazard", 32'(bus.hazard_stall_o), 32'd0);
    step("use r0");
    set_id(5'd2, 5'd0, 5'd12, 1, 0, CTRL_LW);
    step("lw r12");
    set_id(5'd12, 5'd12, 5'd13, 1, 1, CTRL_ADD);
    bus.id_valid_i = 0;
    #1 check("invalid id hazard", 32'(bus.hazard_stall_o), 32'd0);
    bus.id_valid_i = 1;
    bus.stall_i = 1;
    #1 check("stalled hazard", 32'(bus.hazard_stall_o), 32'd0);

    // Stall+flush holds; flush alone bubbles.
    bus.flush_i = 1;
    step("stall+flush");
    check("hold valid", 32'(bus.ex_valid_o), 32'd1);
    check("hold rd", 32'(bus.ex_rd_addr_o), 32'd12);
    bus.stall_i = 0;
    step("flush");
    check("flush valid", 32'(bus.ex_valid_o), 32'd0);
    check("flush ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    idle();

    // Randomized traffic with a small register window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      bus.id_valid_i     = ($urandom_range(0, 9) < 8);
      bus.id_rs_addr_i   = 5'($urandom_range(0, 7));
      bus.id_rt_addr_i   = 5'($urandom_range(0, 7));
      bus.id_rd_addr_i   = 5'($urandom_range(0, 7));
      bus.id_rs_data_i   = $urandom;
      bus.id_rt_data_i   = $urandom;
      bus.id_uses_rs_i   = 1'($urandom);
      bus.id_uses_rt_i   = 1'($urandom);
      bus.id_imm_i       = $urandom;
      bus.id_ctrl_i      = 10'($urandom);
      bus.wb_reg_write_i = 1'($urandom);
      bus.wb_rd_addr_i   = 5'($urandom_range(0, 7));
      bus.wb_rd_data_i   = $urandom;
      bus.stall_i        = ($urandom_range(0, 99) < 15);
      bus.flush_i        = ($urandom_range(0, 99) < 10);
      step("rand");
    end

    // Asynchronous reset between edges discards the EX contents at once.
    bus.stall_i = 0; bus.flush_i = 0;
    set_id(5'd4, 5'd5, 5'd6, 1, 1, CTRL_LW);
    step("pre-reset");
    #2 rst_n = 1'b0;
    #1;
    m = '0;
    check_ex("midreset");
    check("midreset hazard_stall", 32'(bus.hazard_stall_o), 32'd0);
    #1 rst_n = 1'b1;
    idle();
    step("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
